veda_lsu: RTL and testbench

Load/store initiator for the processor's single-port data memory. It accepts one load or store request at a time from the core over a valid/ready handshake, drives the memory's opcode, address and write-data inputs, and samples read data after a fixed memory latency. It returns one response per request over a second valid/ready handshake and keeps saturating access counters. It sits between the execute stage and the data memory; it is the only driver of the memory's write port.

---
 rtl/veda_lsu.sv | 148 ++++++++++++++
 tb/tb_veda_lsu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/veda_lsu.sv
// veda_lsu: load/store initiator for the single-port data memory.
// Accepts one load or store at a time from the core, drives the memory
// opcode/address/write-data, samples read data after MEM_LATENCY cycles,
// and returns one response per request. Keeps saturating access counters.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake
//   resp_valid/resp_ready/resp_rdata/resp_err       : response handshake
//   mem_opcode/mem_addr/mem_datain/mem_dataout      : data memory port
//   load_count/store_count/err_count                : saturating counters
module veda_lsu #(
  parameter int SIZE          = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEM_LATENCY   = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH:0]   req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [5:0]               mem_opcode,
  output logic [ADDRESS_WIDTH:0]   mem_addr,
  output logic [31:0]              mem_datain,
  input  logic [31:0]              mem_dataout,
  output logic [COUNT_WIDTH-1:0]   load_count,
  output logic [COUNT_WIDTH-1:0]   store_count,
  output logic [COUNT_WIDTH-1:0]   err_count
);

  localparam logic [5:0]             LP_OP_WRITE = 6'b001110;
  localparam logic [ADDRESS_WIDTH:0] LP_SIZE     = (ADDRESS_WIDTH+1)'(SIZE);
  localparam logic [1:0]             LP_LAT      = 2'(MEM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_accept;
  logic                     w_addr_err;
  logic                     r_write;
  logic                     r_err;
  logic [ADDRESS_WIDTH:0]   r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_rdata;
  logic [1:0]               r_lat;
  logic [COUNT_WIDTH-1:0]   r_load_cnt;
  logic [COUNT_WIDTH-1:0]   r_store_cnt;
  logic [COUNT_WIDTH-1:0]   r_err_cnt;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_addr_err = (req_addr >= LP_SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_opcode = 6'b000000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          // Out-of-range addresses skip the memory entirely.
          if (w_addr_err)     w_next = S_RESP;
          else if (req_write) w_next = S_WRITE;
          else                w_next = S_READ;
        end
      end
      S_WRITE: begin
        mem_opcode = LP_OP_WRITE;
        w_next     = S_RESP;
      end
      S_READ: begin
        if (r_lat == LP_LAT) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_lat       <= '0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= '0;
        r_err   <= w_addr_err;
        r_lat   <= '0;
      end
      // Read data is valid in the final READ cycle (after MEM_LATENCY cycles).
      if (r_state == S_READ) begin
        r_lat <= r_lat + 1'b1;
        if (r_lat == LP_LAT) r_rdata <= mem_dataout;
      end
      if (r_state == S_RESP && resp_ready) begin
        if (r_err)        r_err_cnt   <= sat_inc(r_err_cnt);
        else if (r_write) r_store_cnt <= sat_inc(r_store_cnt);
        else              r_load_cnt  <= sat_inc(r_load_cnt);
      end
    end
  end

  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign mem_addr    = r_addr;
  assign mem_datain  = r_wdata;
  assign load_count  = r_load_cnt;
  assign store_count = r_store_cnt;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_veda_lsu.sv
module tb_veda_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_opcode;
  logic [5:0]  mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;
  logic [15:0] load_count;
  logic [15:0] store_count;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  // Bench memory: one-cycle registered read, write on the write strobe.
  logic [31:0] mem [0:63];
  logic        tb_init;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  veda_lsu #(
    .SIZE(32), .ADDRESS_WIDTH(5), .MEM_LATENCY(1), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .load_count(load_count), .store_count(store_count), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i < 11) ? 32'((i + 1) * 10) : 32'h0;
      mem_dataout <= 32'h0;
    end else begin
      if (mem_opcode == 6'b001110) begin
        mem[mem_addr] <= mem_datain;
        wr_cnt        <= wr_cnt + 1;
      end
      mem_dataout <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after the accept edge.
  task automatic do_req(input logic wr, input logic [5:0] a, input logic [31:0] d);
    logic got;
    got       = 1'b0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready) got = 1'b1;
      else tick();
    end
    chk("accept", {31'h0, got}, 32'h1);
    tick();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid.
  task automatic wait_resp();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid) got = 1'b1;
      else tick();
    end
    chk("resp_wait", {31'h0, got}, 32'h1);
  endtask

  // Complete the response handshake in one cycle.
  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int wr_before;
    rst        = 1'b0;
    tb_init    = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 6'd0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tb_init = 1'b0;

    // Reset values
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", {26'h0, mem_addr}, 32'h0);
    chk("rst_mem_datain", mem_datain, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("idle_opcode", {26'h0, mem_opcode}, 32'h0);
    end
    chk("idle_counts", {load_count, store_count ^ err_count}, 32'h0);

    // Load addr 3: resp_valid two edges after accept, data 40
    do_req(1'b0, 6'd3, 32'h0);
    chk("ld_ready_low", {31'h0, req_ready}, 32'h0);
    chk("ld_valid_e0", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("ld_valid_e1", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("ld_valid_e2", {31'h0, resp_valid}, 32'h1);
    chk("ld_rdata", resp_rdata, 32'd40);
    chk("ld_err", {31'h0, resp_err}, 32'h0);
    handshake();
    chk("ld_count", {16'h0, load_count}, 32'd1);
    chk("ld_idle", {31'h0, req_ready}, 32'h1);

    // Store 0xDEADBEEF to addr 5: single-cycle write strobe
    wr_before = wr_cnt;
    do_req(1'b1, 6'd5, 32'hDEADBEEF);
    chk("st_opcode", {26'h0, mem_opcode}, 32'h0000000E);
    chk("st_addr", {26'h0, mem_addr}, 32'd5);
    chk("st_datain", mem_datain, 32'hDEADBEEF);
    tick();
    chk("st_opcode_off", {26'h0, mem_opcode}, 32'h0);
    chk("st_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("st_rdata", resp_rdata, 32'h0);
    chk("st_wr_once", 32'(wr_cnt - wr_before), 32'd1);
    chk("st_mem5", mem[5], 32'hDEADBEEF);
    handshake();
    chk("st_count", {16'h0, store_count}, 32'd1);
    do_req(1'b0, 6'd5, 32'h0);
    tick();
    tick();
    chk("st_ld_valid", {31'h0, resp_valid}, 32'h1);
    chk("st_ld_rdata", resp_rdata, 32'hDEADBEEF);
    handshake();
    chk("st_ld_count", {16'h0, load_count}, 32'd2);

    // Error: addr 40 is out of range
    wr_before = wr_cnt;
    do_req(1'b0, 6'd40, 32'h0);
    chk("err_opcode", {26'h0, mem_opcode}, 32'h0);
    chk("err_valid_a", {31'h0, resp_valid}, 32'h1);
    tick();
    chk("err_valid_b", {31'h0, resp_valid}, 32'h1);
    chk("err_flag", {31'h0, resp_err}, 32'h1);
    chk("err_rdata", resp_rdata, 32'h0);
    handshake();
    chk("err_count", {16'h0, err_count}, 32'd1);
    chk("err_no_write", 32'(wr_cnt - wr_before), 32'd0);
    chk("err_mem40", mem[40], 32'h0);
    chk("err_ld_count", {16'h0, load_count}, 32'd2);

    // Backpressure: load addr 0, hold resp_ready low with a competing request
    do_req(1'b0, 6'd0, 32'h0);
    wait_resp();
    req_write = 1'b1;
    req_addr  = 6'd2;
    req_wdata = 32'h55AA55AA;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_rdata", resp_rdata, 32'd10);
      chk("bp_ready", {31'h0, req_ready}, 32'h0);
      tick();
    end
    req_valid = 1'b0;
    handshake();
    chk("bp_count", {16'h0, load_count}, 32'd3);
    tick();
    chk("bp_not_queued", {31'h0, req_ready}, 32'h1);
    chk("bp_no_resp", {31'h0, resp_valid}, 32'h0);
    chk("bp_store_count", {16'h0, store_count}, 32'd1);
    chk("bp_mem2", mem[2], 32'd30);

    // Reset during READ
    do_req(1'b0, 6'd1, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rr_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rr_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rr_mem_addr", {26'h0, mem_addr}, 32'h0);
    chk("rr_load_count", {16'h0, load_count}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rr_idle", {31'h0, resp_valid}, 32'h0);

    // Reset during WRITE: store must not land
    wr_before = wr_cnt;
    do_req(1'b1, 6'd7, 32'h12345678);
    chk("rw_opcode_on", {26'h0, mem_opcode}, 32'h0000000E);
    #1 rst = 1'b0;
    #1;
    chk("rw_opcode_off", {26'h0, mem_opcode}, 32'h0);
    chk("rw_mem_datain", mem_datain, 32'h0);
    chk("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rw_no_write", 32'(wr_cnt - wr_before), 32'd0);
    chk("rw_mem7", mem[7], 32'd80);
    chk("rw_store_count", {16'h0, store_count}, 32'h0);

    // Normal load after reset
    do_req(1'b0, 6'd1, 32'h0);
    wait_resp();
    chk("post_rdata", resp_rdata, 32'd20);
    chk("post_err", {31'h0, resp_err}, 32'h0);
    handshake();
    chk("post_count", {16'h0, load_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
